// File: rtl/pool_pkg.sv
// Shared parameters, pooling mode encoding and lane-width helper for the
// per-channel 2x2 pooling engine.
package pool_pkg;

    localparam int CHANNELS = 64;
    localparam int DW       = 32;
    localparam int WIN      = 4;
    localparam int LOG2_WIN = $clog2(WIN);

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Accumulator width: a full window sum of signed DW-bit values cannot overflow it.
    function automatic int lane_width(input int dw, input int log2_win);
        return dw + log2_win;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the pooling datapath: running accumulator plus the combinational
// max / sum / shift stage that forms the window result on the last vector.
module pool_lane
    import pool_pkg::*;
#(
    parameter int DW  = pool_pkg::DW,
    parameter int WIN = pool_pkg::WIN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          first,
    input  logic          last,
    input  pool_mode_e    mode_q,
    input  logic [DW-1:0] x,
    output logic [DW-1:0] result
);

    localparam int LW = $clog2(WIN);
    localparam int AW = lane_width(DW, LW);

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] x_ext_s;
    logic signed [AW-1:0] sum_s;
    logic signed [AW-1:0] max_s;
    logic signed [AW-1:0] avg_s;

    // Sign-extended operand, running sum, running max and the scaled average.
    always_comb begin
        x_ext_s = {{LW{x[DW-1]}}, x};
        sum_s   = acc_q + x_ext_s;
        if (x_ext_s > acc_q) begin
            max_s = x_ext_s;
        end else begin
            max_s = acc_q;
        end
        avg_s = sum_s >>> LW;
    end

    // Window result: the final vector is folded in here but never stored.
    always_comb begin
        if (mode_q == POOL_AVG) begin
            result = avg_s[DW-1:0];
        end else begin
            result = max_s[DW-1:0];
        end
    end

    // Accumulator next state: load on the first vector, fold on middle vectors.
    always_comb begin
        acc_d = acc_q;
        if (en && first) begin
            acc_d = x_ext_s;
        end else if (en && !last) begin
            if (mode_q == POOL_AVG) begin
                acc_d = sum_s;
            end else begin
                acc_d = max_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {AW{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pool_core.sv
// Per-channel 2x2 pooling engine: window counter, mode latch, one-entry output
// slot behind valid/ready, per-frame window counting and sticky overrun flag.
module pool_core
    import pool_pkg::*;
#(
    parameter int CHANNELS = pool_pkg::CHANNELS,
    parameter int DW       = pool_pkg::DW,
    parameter int WIN      = pool_pkg::WIN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   mode,
    input  logic [15:0]            num_windows,
    input  logic [CHANNELS*DW-1:0] pool_in,
    input  logic                   in_valid,
    output logic [CHANNELS*DW-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int LW = $clog2(WIN);
    localparam logic [LW-1:0] LAST_CNT = LW'(WIN - 1);
    localparam logic [LW-1:0] CNT_ONE  = LW'(1);

    logic [LW-1:0]          win_cnt_q,   win_cnt_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    pool_mode_e             mode_q,      mode_d;
    logic [CHANNELS*DW-1:0] out_data_q,  out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overrun_q,   overrun_d;

    logic                   first_s;
    logic                   last_s;
    logic                   lane_en_s;
    logic                   slot_free_s;
    logic [CHANNELS*DW-1:0] result_s;

    assign first_s     = (win_cnt_q == {LW{1'b0}});
    assign last_s      = (win_cnt_q == LAST_CNT);
    assign lane_en_s   = in_valid && !clear;
    assign slot_free_s = !out_valid_q || out_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pool_lane #(
            .DW  (DW),
            .WIN (WIN)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (lane_en_s),
            .first  (first_s),
            .last   (last_s),
            .mode_q (mode_q),
            .x      (pool_in[c*DW +: DW]),
            .result (result_s[c*DW +: DW])
        );
    end

    // Control next state: clear wins; a completion either fills the slot or is dropped.
    always_comb begin
        win_cnt_d    = win_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        mode_d       = mode_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        if (clear) begin
            win_cnt_d   = {LW{1'b0}};
            frame_cnt_d = 16'd0;
            out_data_d  = {(CHANNELS*DW){1'b0}};
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (in_valid) begin
                if (first_s) begin
                    mode_d = pool_mode_e'(mode);
                end else begin
                    mode_d = mode_q;
                end
                if (last_s) begin
                    win_cnt_d = {LW{1'b0}};
                    if (slot_free_s) begin
                        out_data_d  = result_s;
                        out_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    if ((num_windows != 16'd0) && (frame_cnt_q == num_windows - 16'd1)) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = 16'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end else begin
                    win_cnt_d = win_cnt_q + CNT_ONE;
                end
            end else begin
                win_cnt_d = win_cnt_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q    <= {LW{1'b0}};
            frame_cnt_q  <= 16'd0;
            mode_q       <= POOL_MAX;
            out_data_q   <= {(CHANNELS*DW){1'b0}};
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            mode_q       <= mode_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pool_core.sv
// Randomized and directed bench for pool_core: a window-level reference model
// pushes expected results into a queue that a negedge monitor checks.
module tb_pool_core;
    import pool_pkg::*;

    localparam int VW = CHANNELS * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          mode;
    logic [15:0]   num_windows;
    logic [VW-1:0] pool_in;
    logic          in_valid;
    logic [VW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;
    logic          overrun;

    pool_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .mode        (mode),
        .num_windows (num_windows),
        .pool_in     (pool_in),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] win_buf[WIN];
    int            m_cnt  = 0;
    int            m_fcnt = 0;
    logic          m_mode = 1'b0;
    logic          m_full = 1'b0;
    logic          m_ovr  = 1'b0;
    logic          e_fd   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result of one complete window: signed max, or floor of the mean.
    function automatic logic [VW-1:0] model_window(input logic md);
        logic [VW-1:0] r;
        for (int c = 0; c < CHANNELS; c++) begin
            longint best;
            longint sum;
            logic [DW-1:0] v;
            v = win_buf[0][c*DW +: DW];
            best = longint'($signed(v));
            sum = 0;
            for (int k = 0; k < WIN; k++) begin
                longint e;
                v = win_buf[k][c*DW +: DW];
                e = longint'($signed(v));
                sum += e;
                if (e > best) best = e;
            end
            if (md) r[c*DW +: DW] = DW'(sum >>> LOG2_WIN);
            else    r[c*DW +: DW] = DW'(best);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] mkvec(input logic [DW-1:0] l0, input logic [DW-1:0] l63);
        logic [VW-1:0] v;
        for (int c = 0; c < CHANNELS; c++) v[c*DW +: DW] = $urandom;
        v[DW-1:0] = l0;
        v[(CHANNELS-1)*DW +: DW] = l63;
        return v;
    endfunction

    // One clock of stimulus; the model predicts the state after the coming edge.
    task automatic step(input logic iv, input logic [VW-1:0] vec, input logic md,
                        input logic rdy, input logic clr);
        logic nfull;
        logic novr;
        logic nfd;
        in_valid = iv; pool_in = vec; mode = md; out_ready = rdy; clear = clr;
        nfull = m_full; novr = m_ovr; nfd = 1'b0;
        if (clr) begin
            nfull = 1'b0; novr = 1'b0; m_cnt = 0; m_fcnt = 0;
        end else begin
            if (m_full && rdy) nfull = 1'b0;
            if (iv) begin
                win_buf[m_cnt] = vec;
                if (m_cnt == 0) m_mode = md;
                if (m_cnt == WIN - 1) begin
                    if (!m_full || rdy) begin
                        exp_q.push_back(model_window(m_mode));
                        nfull = 1'b1;
                    end else begin
                        novr = 1'b1;
                    end
                    if (num_windows != 16'd0 && m_fcnt == int'(num_windows) - 1) begin
                        nfd = 1'b1; m_fcnt = 0;
                    end else begin
                        m_fcnt = m_fcnt + 1;
                    end
                    m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        @(posedge clk);
        if (clr) exp_q.delete();
        m_full = nfull; m_ovr = novr; e_fd = nfd;
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, {VW{1'b0}}, 1'b0, rdy, 1'b0);
    endtask

    // Monitor: flags every cycle, output data against the scoreboard head.
    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        if (out_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_data: got valid output but scoreboard empty at %0t", $time);
            end else if (out_data !== exp_q[0]) begin
                n_err++;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (out_data[c*DW +: DW] !== exp_q[0][c*DW +: DW]) begin
                        $display("FAIL out_data lane %0d: got %h expected %h at %0t",
                                 c, out_data[c*DW +: DW], exp_q[0][c*DW +: DW], $time);
                        break;
                    end
                end
            end
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        int fd_cnt;
        rst_n = 1'b0; clear = 1'b0; mode = 1'b0; num_windows = 16'd0;
        pool_in = {VW{1'b0}}; in_valid = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_out_data", {31'd0, (out_data == {VW{1'b0}})}, 32'd1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Max window.
        step(1'b1, mkvec(32'd5, 32'd0), 1'b0, 1'b1, 1'b0);
        step(1'b1, mkvec(-32'sd3, 32'd0), 1'b0, 1'b1, 1'b0);
        step(1'b1, mkvec(32'd9, 32'd0), 1'b0, 1'b1, 1'b0);
        step(1'b1, mkvec(32'd2, 32'd0), 1'b0, 1'b1, 1'b0);
        chk("max_valid", {31'd0, out_valid}, 32'd1);
        chk("max_lane0", out_data[DW-1:0], 32'd9);
        idle(1'b1);
        chk("max_pulse", {31'd0, out_valid}, 32'd0);

        // Average window with negative sum and a rounding-down lane.
        step(1'b1, mkvec(-32'sd1, 32'd7), 1'b1, 1'b1, 1'b0);
        step(1'b1, mkvec(-32'sd2, 32'd7), 1'b0, 1'b1, 1'b0);
        step(1'b1, mkvec(-32'sd3, 32'd7), 1'b0, 1'b1, 1'b0);
        step(1'b1, mkvec(-32'sd4, 32'd8), 1'b0, 1'b1, 1'b0);
        chk("avg_lane0", out_data[DW-1:0], 32'hFFFF_FFFD);
        chk("avg_lane63", out_data[(CHANNELS-1)*DW +: DW], 32'd7);
        idle(1'b1);

        // Backpressure across two windows.
        for (int i = 0; i < 2 * WIN; i++) step(1'b1, mkvec($urandom, $urandom), 1'b0, 1'b0, 1'b0);
        chk("bp_overrun", {31'd0, overrun}, 32'd1);
        idle(1'b1);
        idle(1'b1);
        chk("bp_sticky", {31'd0, overrun}, 32'd1);
        step(1'b0, {VW{1'b0}}, 1'b0, 1'b1, 1'b1);
        chk("clear_overrun", {31'd0, overrun}, 32'd0);

        // Completion with ready while the slot is full.
        for (int i = 0; i < WIN; i++) step(1'b1, mkvec($urandom, $urandom), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < WIN - 1; i++) step(1'b1, mkvec($urandom, $urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, mkvec(32'd77, 32'd1), 1'b0, 1'b1, 1'b0);
        chk("swap_valid", {31'd0, out_valid}, 32'd1);
        chk("swap_no_ovr", {31'd0, overrun}, 32'd0);
        idle(1'b1);

        // Frame counting.
        step(1'b0, {VW{1'b0}}, 1'b0, 1'b1, 1'b1);
        num_windows = 16'd3;
        fd_cnt = 0;
        for (int i = 0; i < 6 * WIN; i++) begin
            step(1'b1, mkvec($urandom, $urandom), 1'($urandom), 1'b1, 1'b0);
            if (frame_done) fd_cnt++;
        end
        chk("frame_pulses", fd_cnt, 32'd2);
        num_windows = 16'd0;
        fd_cnt = 0;
        for (int i = 0; i < 6 * WIN; i++) begin
            step(1'b1, mkvec($urandom, $urandom), 1'($urandom), 1'b1, 1'b0);
            if (frame_done) fd_cnt++;
        end
        chk("frame_off", fd_cnt, 32'd0);

        // Reset in the middle of a window.
        step(1'b1, mkvec(32'd100, 32'd0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mkvec(32'd200, 32'd0), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        m_full = 1'b0; m_ovr = 1'b0; e_fd = 1'b0; m_cnt = 0; m_fcnt = 0;
        exp_q.delete();
        in_valid = 1'b0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data0", {31'd0, (out_data == {VW{1'b0}})}, 32'd1);
        chk("rst_fd_ovr", {30'd0, frame_done, overrun}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, mkvec(32'd1, 32'd0), 1'b0, 1'b1, 1'b0);
        step(1'b1, mkvec(32'd4, 32'd0), 1'b0, 1'b1, 1'b0);
        step(1'b1, mkvec(32'd3, 32'd0), 1'b0, 1'b1, 1'b0);
        step(1'b1, mkvec(32'd2, 32'd0), 1'b0, 1'b1, 1'b0);
        chk("post_rst_lane0", out_data[DW-1:0], 32'd4);
        idle(1'b1);

        // Random traffic with backpressure and occasional clears.
        num_windows = 16'd3;
        for (int i = 0; i < 600; i++) begin
            logic clr;
            clr = ($urandom_range(0, 79) == 0);
            if (i == 300) begin
                step(1'b0, {VW{1'b0}}, 1'b0, 1'b1, 1'b1);
                num_windows = 16'd2;
            end
            step(1'($urandom_range(0, 3) != 0), mkvec($urandom, $urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0), clr);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
